// File: rtl/fnd_pkg.sv
// Shared types and defaults for the FND page scheduler: state encoding, page ids, timing defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHOW_A   = 2'd1,
        ST_SHOW_B   = 2'd2,
        ST_OVERRIDE = 2'd3
    } state_e;

    localparam logic [1:0] PAGE_BLANK = 2'd0;
    localparam logic [1:0] PAGE_A     = 2'd1;
    localparam logic [1:0] PAGE_B     = 2'd2;
    localparam logic [1:0] PAGE_OVR   = 2'd3;

    localparam int DEF_TICK_DIV = 100_000;
    localparam int DEF_PAGE_MS  = 2000;
    localparam int DEF_OVR_MS   = 1000;

endpackage

// File: rtl/fnd_page_scheduler_ms_timebase.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, restartable with clr.
// Latency: tick asserted on the TICK_DIV-th cycle after clr (counter value TICK_DIV-1).
// Backpressure: none; free-running, clr wins over counting.
module ms_timebase
    import fnd_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Count up to LAST then wrap; a clear restarts the millisecond from zero.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fnd_page_scheduler.sv
// Rotates the FND display between sensor pages A/B with a preemptive override page.
// Latency: outputs registered from next state/data, so they change on the same edge as the state.
// Backpressure: none; ovr_req is a level request answered by a one-cycle ovr_ack pulse.
module fnd_page_scheduler
    import fnd_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PAGE_MS  = DEF_PAGE_MS,
    parameter int OVR_MS   = DEF_OVR_MS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       a_valid,
    input  logic [7:0] a_hi,
    input  logic [7:0] a_lo,
    input  logic       b_valid,
    input  logic [7:0] b_hi,
    input  logic [7:0] b_lo,
    input  logic       ovr_req,
    input  logic [7:0] ovr_hi,
    input  logic [7:0] ovr_lo,
    output logic       ovr_ack,
    output logic [7:0] disp_hi,
    output logic [7:0] disp_lo,
    output logic [1:0] page_id,
    output logic       blank
);

    localparam int PMAX = (PAGE_MS > OVR_MS) ? PAGE_MS : OVR_MS;
    localparam int PCW  = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PCW-1:0] PAGE_LAST = PCW'(PAGE_MS - 1);
    localparam logic [PCW-1:0] OVR_LAST  = PCW'(OVR_MS - 1);

    state_e         state_q, state_d, ret_q, ret_d, nxt_page;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [7:0]     a_hi_q, a_lo_q, b_hi_q, b_lo_q, o_hi_q, o_lo_q;
    logic [7:0]     a_hi_d, a_lo_d, b_hi_d, b_lo_d, o_hi_d, o_lo_d;
    logic           have_a_q, have_b_q, have_a_d, have_b_d;
    logic           ack_q, ack_d;
    logic [7:0]     disp_hi_q, disp_lo_q, disp_hi_d, disp_lo_d;
    logic [1:0]     page_q, page_d;
    logic           blank_q, blank_d;
    logic           tick, tb_clr, expire, restart;

    ms_timebase #(.TICK_DIV(TICK_DIV)) u_tb (
        .clk   (clk),
        .reset (reset),
        .clr   (tb_clr),
        .tick  (tick)
    );

    // Next-state, shadow capture, dwell timer and registered-output preparation.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        nxt_page = state_q;
        ack_d    = 1'b0;
        restart  = 1'b0;
        a_hi_d   = a_valid ? a_hi : a_hi_q;
        a_lo_d   = a_valid ? a_lo : a_lo_q;
        b_hi_d   = b_valid ? b_hi : b_hi_q;
        b_lo_d   = b_valid ? b_lo : b_lo_q;
        have_a_d = have_a_q | a_valid;
        have_b_d = have_b_q | b_valid;
        o_hi_d   = o_hi_q;
        o_lo_d   = o_lo_q;
        expire   = tick && (pcnt_q == ((state_q == ST_OVERRIDE) ? OVR_LAST : PAGE_LAST));

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (have_a_q)      state_d = ST_SHOW_A;
                    else if (have_b_q) state_d = ST_SHOW_B;
                end
                ST_SHOW_A, ST_SHOW_B: begin
                    // Page the timer would move to; also the return page if an override lands now.
                    if (expire) begin
                        if (state_q == ST_SHOW_A && have_b_q)      nxt_page = ST_SHOW_B;
                        else if (state_q == ST_SHOW_B && have_a_q) nxt_page = ST_SHOW_A;
                        else                                       restart  = 1'b1;
                    end
                    if (ovr_req) begin
                        ack_d   = 1'b1;
                        ret_d   = nxt_page;
                        state_d = ST_OVERRIDE;
                    end else begin
                        state_d = nxt_page;
                    end
                end
                ST_OVERRIDE: begin
                    // A held request is only re-acknowledged at dwell expiry, extending the override.
                    if (expire) begin
                        if (ovr_req) begin
                            ack_d   = 1'b1;
                            restart = 1'b1;
                        end else begin
                            state_d = ret_q;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (ack_d) begin
            o_hi_d = ovr_hi;
            o_lo_d = ovr_lo;
        end

        // Every state entry or restart starts a fresh dwell; IDLE keeps the timer parked at zero.
        tb_clr = restart || (state_d != state_q) || (state_q == ST_IDLE);
        pcnt_d = pcnt_q;
        if (tb_clr)    pcnt_d = '0;
        else if (tick) pcnt_d = pcnt_q + PCW'(1);

        disp_hi_d = 8'h00;
        disp_lo_d = 8'h00;
        page_d    = PAGE_BLANK;
        blank_d   = 1'b1;
        case (state_d)
            ST_SHOW_A: begin
                disp_hi_d = a_hi_d; disp_lo_d = a_lo_d; page_d = PAGE_A; blank_d = 1'b0;
            end
            ST_SHOW_B: begin
                disp_hi_d = b_hi_d; disp_lo_d = b_lo_d; page_d = PAGE_B; blank_d = 1'b0;
            end
            ST_OVERRIDE: begin
                disp_hi_d = o_hi_d; disp_lo_d = o_lo_d; page_d = PAGE_OVR; blank_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State, shadows, timer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            pcnt_q    <= '0;
            a_hi_q    <= '0;
            a_lo_q    <= '0;
            b_hi_q    <= '0;
            b_lo_q    <= '0;
            o_hi_q    <= '0;
            o_lo_q    <= '0;
            have_a_q  <= 1'b0;
            have_b_q  <= 1'b0;
            ack_q     <= 1'b0;
            disp_hi_q <= '0;
            disp_lo_q <= '0;
            page_q    <= PAGE_BLANK;
            blank_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            pcnt_q    <= pcnt_d;
            a_hi_q    <= a_hi_d;
            a_lo_q    <= a_lo_d;
            b_hi_q    <= b_hi_d;
            b_lo_q    <= b_lo_d;
            o_hi_q    <= o_hi_d;
            o_lo_q    <= o_lo_d;
            have_a_q  <= have_a_d;
            have_b_q  <= have_b_d;
            ack_q     <= ack_d;
            disp_hi_q <= disp_hi_d;
            disp_lo_q <= disp_lo_d;
            page_q    <= page_d;
            blank_q   <= blank_d;
        end
    end

    assign ovr_ack = ack_q;
    assign disp_hi = disp_hi_q;
    assign disp_lo = disp_lo_q;
    assign page_id = page_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_fnd_page_scheduler.sv
// Scoreboard bench for fnd_page_scheduler: cycle-count reference model feeds an expected-output queue.
// Latency: expected record per clock, compared on the following falling edge.
// Backpressure: n/a.
module tb_fnd_page_scheduler;

    localparam int TD = 4;
    localparam int PM = 3;
    localparam int OM = 2;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [1:0] pid;
        logic       blank;
        logic       ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0, ovr_req = 1'b0;
    logic [7:0] a_hi = 8'h00, a_lo = 8'h00, b_hi = 8'h00, b_lo = 8'h00;
    logic [7:0] ovr_hi = 8'h00, ovr_lo = 8'h00;
    logic       ovr_ack, blank;
    logic [7:0] disp_hi, disp_lo;
    logic [1:0] page_id;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Reference model state: state number (0 idle,1 A,2 B,3 override), cycles spent in current dwell.
    int         m_state = 0, m_cnt = 0, m_ret = 0;
    bit         m_have_a = 0, m_have_b = 0;
    logic [7:0] m_a_hi = 0, m_a_lo = 0, m_b_hi = 0, m_b_lo = 0, m_o_hi = 0, m_o_lo = 0;

    fnd_page_scheduler #(.TICK_DIV(TD), .PAGE_MS(PM), .OVR_MS(OM)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .a_valid (a_valid),
        .a_hi    (a_hi),
        .a_lo    (a_lo),
        .b_valid (b_valid),
        .b_hi    (b_hi),
        .b_lo    (b_lo),
        .ovr_req (ovr_req),
        .ovr_hi  (ovr_hi),
        .ovr_lo  (ovr_lo),
        .ovr_ack (ovr_ack),
        .disp_hi (disp_hi),
        .disp_lo (disp_lo),
        .page_id (page_id),
        .blank   (blank)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int   nxt, dw, tgt;
        bit   exp_now, ack;
        exp_t e;
        ack = 0;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_ret = 0; m_have_a = 0; m_have_b = 0;
            m_a_hi = 0; m_a_lo = 0; m_b_hi = 0; m_b_lo = 0; m_o_hi = 0; m_o_lo = 0;
        end else begin
            dw      = (m_state == 3) ? OM * TD : PM * TD;
            exp_now = (m_state != 0) && (m_cnt == dw - 1);
            nxt     = m_state;
            if (!enable) begin
                nxt = 0;
            end else if (m_state == 0) begin
                if (m_have_a)      nxt = 1;
                else if (m_have_b) nxt = 2;
            end else if (m_state == 3) begin
                if (exp_now) begin
                    if (ovr_req) ack = 1;
                    else         nxt = m_ret;
                end
            end else begin
                tgt = m_state;
                if (exp_now && ((m_state == 1) ? m_have_b : m_have_a)) tgt = 3 - m_state;
                if (ovr_req) begin
                    ack = 1; nxt = 3; m_ret = tgt;
                end else begin
                    nxt = tgt;
                end
            end
            if (ack) begin m_o_hi = ovr_hi; m_o_lo = ovr_lo; end
            if (a_valid) begin m_a_hi = a_hi; m_a_lo = a_lo; m_have_a = 1; end
            if (b_valid) begin m_b_hi = b_hi; m_b_lo = b_lo; m_have_b = 1; end
            if (nxt != m_state || exp_now || nxt == 0) m_cnt = 0;
            else                                       m_cnt = m_cnt + 1;
            m_state = nxt;
        end
        e.pid   = 2'(m_state);
        e.blank = (m_state == 0);
        e.ack   = ack;
        case (m_state)
            1:       begin e.hi = m_a_hi; e.lo = m_a_lo; end
            2:       begin e.hi = m_b_hi; e.lo = m_b_lo; end
            3:       begin e.hi = m_o_hi; e.lo = m_o_lo; end
            default: begin e.hi = 8'h00;  e.lo = 8'h00;  end
        endcase
        exp_q.push_back(e);
    endtask

    // Model: evaluates the inputs seen at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: pops one expected record per cycle and compares all outputs.
    exp_t got, want;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {disp_hi, disp_lo, page_id, blank, ovr_ack};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs t=%0t got hi=%h lo=%h page=%0d blank=%0b ack=%0b want hi=%h lo=%h page=%0d blank=%0b ack=%0b",
                             $time, got.hi, got.lo, got.pid, got.blank, got.ack,
                             want.hi, want.lo, want.pid, want.blank, want.ack);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the model is in state s, optionally at dwell cycle c (c < 0: any).
    task automatic wait_model(input int s, input int c, input string tag);
        int k;
        k = 0;
        while (!(m_state == s && (c < 0 || m_cnt == c)) && k < 300) begin
            cyc(1);
            k++;
        end
        if (k >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_%s timeout state=%0d cnt=%0d required state=%0d cnt=%0d", tag, m_state, m_cnt, s, c);
        end
    endtask

    task automatic pulse_ovr(input logic [7:0] hi, input logic [7:0] lo);
        ovr_req = 1'b1; ovr_hi = hi; ovr_lo = lo;
        cyc(1);
        ovr_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cyc(3);
        reset  = 1'b0;
        enable = 1'b1;
        cyc(4);
        // Page A only: must stay on A across several dwells.
        a_valid = 1'b1; a_hi = 8'h19; a_lo = 8'h2D;
        cyc(1);
        a_valid = 1'b0;
        cyc(30);
        // Add page B: alternation every dwell.
        b_valid = 1'b1; b_hi = 8'h05; b_lo = 8'h07;
        cyc(1);
        b_valid = 1'b0;
        cyc(40);
        // Override pulse in SHOW_B, then full B dwell after return.
        wait_model(2, 3, "showb");
        pulse_ovr(8'hAA, 8'h55);
        cyc(30);
        // Override on the expiry cycle of SHOW_A: returns to B.
        wait_model(1, PM * TD - 1, "expa");
        pulse_ovr(8'h3C, 8'hC3);
        cyc(25);
        // Held request extends the override.
        wait_model(1, 2, "showa");
        ovr_req = 1'b1; ovr_hi = 8'h11; ovr_lo = 8'h22;
        cyc(20);
        ovr_req = 1'b0;
        cyc(15);
        // Enable drop during override blanks next cycle; re-enable restarts at A.
        wait_model(2, -1, "showb2");
        pulse_ovr(8'h77, 8'h88);
        cyc(3);
        enable = 1'b0;
        cyc(4);
        enable = 1'b1;
        cyc(20);
        // Reset mid-SHOW_B: idle until new data, then both valids at once.
        wait_model(2, 5, "showb3");
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(10);
        a_valid = 1'b1; a_hi = 8'h42; a_lo = 8'h24;
        b_valid = 1'b1; b_hi = 8'h99; b_lo = 8'h66;
        cyc(1);
        a_valid = 1'b0; b_valid = 1'b0;
        cyc(30);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            a_valid = ($urandom_range(0, 19) == 0);
            b_valid = ($urandom_range(0, 19) == 0);
            a_hi = 8'($urandom); a_lo = 8'($urandom);
            b_hi = 8'($urandom); b_lo = 8'($urandom);
            ovr_hi = 8'($urandom); ovr_lo = 8'($urandom);
            if (ovr_req) ovr_req = ($urandom_range(0, 3) != 0);
            else         ovr_req = ($urandom_range(0, 29) == 0);
            if (enable) enable = ($urandom_range(0, 49) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        a_valid = 1'b0; b_valid = 1'b0; ovr_req = 1'b0; reset = 1'b0;
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_page_scheduler.md
FND_PAGE_SCHEDULER -- requirements
Module: fnd_page_scheduler

Interface
REQ-001 Parameter TICK_DIV, 100_000, clk cycles per 1 ms tick.
REQ-002 Parameter PAGE_MS, 2000, dwell time per rotating page, in ms ticks.
REQ-003 Parameter OVR_MS, 1000, dwell time of an override page, in ms ticks.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  1 = schedule pages; 0 = blank display.
REQ-007 a_valid  in  1  pulse; latch a_hi/a_lo into page-A shadow.
REQ-008 a_hi, a_lo  in  8 each  page-A data (temperature/humidity).
REQ-009 b_valid  in  1  pulse; latch b_hi/b_lo into page-B shadow.
REQ-010 b_hi, b_lo  in  8 each  page-B data (second sensor pair).
REQ-011 ovr_req  in  1  level request for override display.
REQ-012 ovr_hi, ovr_lo  in  8 each  override data, captured on ovr_ack.
REQ-013 ovr_ack  out  1  one-cycle pulse acknowledging ovr_req.
REQ-014 disp_hi, disp_lo  out  8 each  data forwarded to the fndController tempData/humiData inputs.
REQ-015 page_id  out  2  0=blank, 1=A, 2=B, 3=override.
REQ-016 blank  out  1  1 = display must be dark.

Function
REQ-017 States: IDLE, SHOW_A, SHOW_B, OVERRIDE; all outputs registered, one cycle after state/data change.
REQ-018 Shadow A/B update on their valid pulse in any state; a_valid and b_valid in the same cycle both latch; each sets a sticky have_a/have_b flag.
REQ-019 IDLE: blank=1, page_id=0, disp=0; leave to SHOW_A when enable=1 and have_a=1, else to SHOW_B when enable=1 and have_b=1.
REQ-020 SHOW_A/SHOW_B: disp tracks the page shadow (new valid visible one cycle after latch); blank=0.
REQ-021 Page timer counts ms ticks; on reaching PAGE_MS, switch to the other page if its have flag is set, else restart the timer on the current page.
REQ-022 Page timer and ms prescaler restart to 0 on every state entry, so each dwell is exactly PAGE_MS*TICK_DIV cycles.
REQ-023 ovr_req sampled with enable=1 in SHOW_A/SHOW_B/OVERRIDE: ovr_ack pulses, ovr data captured, enter/restart OVERRIDE; no ack while enable=0 or in IDLE.
REQ-024 OVERRIDE lasts OVR_MS*TICK_DIV cycles, then returns to the saved return page with a fresh page timer.
REQ-025 Return page = page active at request; if ovr_req coincides with page-timer expiry, override wins and return page = page that would have been entered.
REQ-026 ovr_req held high re-acks at most once per OVR_MS dwell (only at dwell expiry), i.e. a held request extends the override.
REQ-027 enable falling in any state forces IDLE next cycle; pending timers discarded.
REQ-028 Counters sized with $clog2 of their limits; no wrap beyond limit; TICK_DIV, PAGE_MS, OVR_MS >= 1.

Reset
REQ-029 reset: state=IDLE, shadows=0, have_a=have_b=0, timers=0, ovr_ack=0, disp=0, page_id=0, blank=1; reset mid-override aborts it with no ack.

Structure
REQ-030 Shared package fnd_pkg holds the state enum, page_id constants and default parameter values.
REQ-031 One sub-module ms_timebase (prescaler with clr input, 1-cycle tick output, parameter TICK_DIV).

Verification (TICK_DIV=4, PAGE_MS=3, OVR_MS=2)
REQ-032 reset, enable=1, a_valid with 0x19/0x2D -> page_id=1, disp=0x19/0x2D, blank=0; stays on A (no B) past 12 cycles.
REQ-033 Then b_valid 0x05/0x07 -> after 12-cycle dwell page_id=2; alternates A/B every 12 cycles.
REQ-034 ovr_req pulse in SHOW_B, data 0xAA/0x55 -> ovr_ack one cycle, page_id=3 for 8 cycles, then page_id=2 for a full 12 cycles.
REQ-035 ovr_req on the page-expiry cycle in SHOW_A -> override wins, return to page B.
REQ-036 enable=0 during OVERRIDE -> blank=1, page_id=0 next cycle; enable=1 restarts at SHOW_A.
REQ-037 reset asserted mid-SHOW_B -> all outputs at reset values next cycle; have flags cleared, stays IDLE until new valid.
